// File: rtl/counter_ctrl.sv
// counter_ctrl: run-control sequencer for a two-digit BCD counter.
//
// Accepts start/stop/clear commands (clear > stop > start), divides clk by
// PRESCALE and advances a BCD count 00..99 until it equals a limit latched
// when the start was accepted. Completion is flagged with a one-cycle done
// pulse; a start carrying a non-BCD limit is rejected with a one-cycle err.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   start     begin / resume / restart command (level sampled)
//   stop      pause command (level sampled)
//   clear     abort command, zeroes the count (level sampled)
//   limit     BCD terminal value {tens, ones}, sampled on an accepted start
//   cnt_ones  BCD ones digit
//   cnt_tens  BCD tens digit
//   state     IDLE=00 RUN=01 PAUSE=10 DONE=11
//   busy      state is RUN or PAUSE
//   done      one-cycle pulse when the count reaches the limit
//   err       one-cycle pulse when a start is rejected
module counter_ctrl #(
    parameter int PRESCALE = 4  // clock cycles per count tick, 1..256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic [7:0] limit,
    output logic [3:0] cnt_ones,
    output logic [3:0] cnt_tens,
    output logic [1:0] state,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    // PRESCALE=256 maps to a terminal prescaler value of 255.
    localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

    state_t     st_q, st_d;
    logic [7:0] psc_q, psc_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic [7:0] lim_q, lim_d;
    logic       done_d, err_d, busy_d;

    // Only the highest-priority asserted command is acted on.
    logic do_clear, do_stop, do_start;
    assign do_clear = clear;
    assign do_stop  = stop & ~clear;
    assign do_start = start & ~stop & ~clear;

    logic limit_ok;
    assign limit_ok = (limit[7:4] <= 4'd9) && (limit[3:0] <= 4'd9);

    logic tick;
    assign tick = (psc_q == PS_LAST);

    // One BCD step; the limit is <= 99, so tens never needs to wrap.
    logic [3:0] inc_ones, inc_tens;
    always_comb begin
        if (ones_q == 4'd9) begin
            inc_ones = 4'd0;
            inc_tens = tens_q + 4'd1;
        end else begin
            inc_ones = ones_q + 4'd1;
            inc_tens = tens_q;
        end
    end

    always_comb begin
        st_d   = st_q;
        psc_d  = psc_q;
        ones_d = ones_q;
        tens_d = tens_q;
        lim_d  = lim_q;
        done_d = 1'b0;
        err_d  = 1'b0;

        case (st_q)
            IDLE, DONE: begin
                if (do_clear) begin
                    st_d   = IDLE;
                    psc_d  = 8'd0;
                    ones_d = 4'd0;
                    tens_d = 4'd0;
                end else if (do_start) begin
                    if (limit_ok) begin
                        lim_d  = limit;
                        psc_d  = 8'd0;
                        ones_d = 4'd0;
                        tens_d = 4'd0;
                        // A 00 limit is already met by the zeroed count.
                        if (limit == 8'h00) begin
                            st_d   = DONE;
                            done_d = 1'b1;
                        end else begin
                            st_d = RUN;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            RUN: begin
                if (do_clear) begin
                    st_d   = IDLE;
                    psc_d  = 8'd0;
                    ones_d = 4'd0;
                    tens_d = 4'd0;
                end else if (do_stop) begin
                    st_d = PAUSE;
                end else if (tick) begin
                    psc_d  = 8'd0;
                    ones_d = inc_ones;
                    tens_d = inc_tens;
                    if ({inc_tens, inc_ones} == lim_q) begin
                        st_d   = DONE;
                        done_d = 1'b1;
                    end
                end else begin
                    psc_d = psc_q + 8'd1;
                end
            end

            PAUSE: begin
                if (do_clear) begin
                    st_d   = IDLE;
                    psc_d  = 8'd0;
                    ones_d = 4'd0;
                    tens_d = 4'd0;
                end else if (do_start) begin
                    // Resume keeps prescaler and latched limit; the limit
                    // input only decides whether the start is accepted.
                    if (limit_ok) st_d = RUN;
                    else          err_d = 1'b1;
                end
            end

            default: st_d = IDLE;
        endcase
    end

    assign busy_d = (st_d == RUN) || (st_d == PAUSE);

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= IDLE;
            psc_q  <= 8'd0;
            ones_q <= 4'd0;
            tens_q <= 4'd0;
            lim_q  <= 8'h00;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            st_q   <= st_d;
            psc_q  <= psc_d;
            ones_q <= ones_d;
            tens_q <= tens_d;
            lim_q  <= lim_d;
            busy   <= busy_d;
            done   <= done_d;
            err    <= err_d;
        end
    end

    assign state    = st_q;
    assign cnt_ones = ones_q;
    assign cnt_tens = tens_q;

endmodule
